// File: rtl/enc_transpose_stream.sv
// Slice transpose: FEATURE_COUNT rows of SLICE_W bits in, SLICE_W columns of FEATURE_COUNT bits out.
// The first column is valid 1 cycle after the last row is accepted. The output holds while out_ready is low, and input stalls during DRAIN.
module enc_transpose_stream #(
   parameter int HV_DIM         = 4096,
   parameter int FEATURE_COUNT  = 617,
   parameter int SLICE_W        = 32,
   parameter int FEAT_MSB_FIRST = 1
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic                        clear,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [SLICE_W-1:0]          in_row,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [FEATURE_COUNT-1:0]    out_col,
   output logic [$clog2(HV_DIM)-1:0]   out_dim,
   output logic                        out_last_col,
   output logic                        out_last,
   output logic                        busy
);

   localparam int SLICES = HV_DIM / SLICE_W;
   localparam int DIM_W  = $clog2(HV_DIM);
   localparam int ROW_W  = (FEATURE_COUNT > 1) ? $clog2(FEATURE_COUNT) : 1;
   localparam int COL_W  = (SLICE_W > 1) ? $clog2(SLICE_W) : 1;
   localparam int SL_W   = (SLICES > 1) ? $clog2(SLICES) : 1;

   if (HV_DIM % SLICE_W != 0) begin : g_bad_dim
      $error("HV_DIM must be a multiple of SLICE_W");
   end

   typedef enum logic {FILL, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [SL_W-1:0]    slice_q, slice_d;
   logic               rdy_en_q, rdy_en_d;
   logic [SLICE_W-1:0] mem_q [FEATURE_COUNT];

   logic in_fire, out_fire, last_row, last_slice;

   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign last_row   = (row_q == ROW_W'(FEATURE_COUNT - 1));
   assign last_slice = (slice_q == SL_W'(SLICES - 1));

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clear overrides any handshake in the same cycle
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = FILL;
      end else begin
         case (state_q)
            FILL:    if (in_fire && last_row) state_d = DRAIN;
            DRAIN:   if (out_fire && out_last_col) state_d = FILL;
            default: state_d = FILL;
         endcase
      end
   end

   // Output decode, purely from registered state and counters
   always_comb begin
      in_ready     = (state_q == FILL) && rdy_en_q;
      out_valid    = (state_q == DRAIN);
      out_last_col = (col_q == COL_W'(SLICE_W - 1));
      out_last     = out_last_col && last_slice;
      out_dim      = DIM_W'(slice_q) * DIM_W'(SLICE_W) + DIM_W'(col_q);
      busy         = !((state_q == FILL) && (row_q == '0) && (slice_q == '0));
   end

   always_comb begin
      row_d    = row_q;
      col_d    = col_q;
      slice_d  = slice_q;
      rdy_en_d = 1'b1;
      if (clear) begin
         row_d   = '0;
         col_d   = '0;
         slice_d = '0;
      end else if (in_fire) begin
         row_d = last_row ? '0 : row_q + 1'b1;
      end else if (out_fire) begin
         col_d = out_last_col ? '0 : col_q + 1'b1;
         if (out_last_col) begin
            slice_d = last_slice ? '0 : slice_q + 1'b1;
         end
      end
   end

   // in_ready stays low until the first edge after reset release
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         row_q    <= '0;
         col_q    <= '0;
         slice_q  <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         row_q    <= row_d;
         col_q    <= col_d;
         slice_q  <= slice_d;
         rdy_en_q <= rdy_en_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire && !clear) begin
         mem_q[row_q] <= in_row;
      end
   end

   for (genvar f = 0; f < FEATURE_COUNT; f++) begin : g_col
      if (FEAT_MSB_FIRST != 0) begin : g_msb
         assign out_col[FEATURE_COUNT-1-f] = mem_q[f][col_q];
      end else begin : g_lsb
         assign out_col[f] = mem_q[f][col_q];
      end
   end

endmodule
